// File: rtl/rdy_ack_sink_checker_if.sv
// rdy/ack handshake bundle between a sender and the sink checker.
// master drives in_rdy/in_data; slave drives in_ack.
interface rdy_ack_sink_checker_if #(
  parameter int DATA_W = 32
);
  logic              in_rdy;
  logic              in_ack;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_rdy,
    output in_data,
    input  in_ack
  );

  modport slave (
    input  in_rdy,
    input  in_data,
    output in_ack
  );
endinterface

// File: rtl/rdy_ack_sink_checker.sv
// rdy/ack sink: LFSR backpressure, in-order expected-FIFO compare, protocol check.
// Ports: clk, rstn, snk (slave), stall_level, exp_* FIFO, counters, sticky errors.
module rdy_ack_sink_checker #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rstn,
  rdy_ack_sink_checker_if.slave snk,
  input  logic [3:0]            stall_level,
  input  logic                  exp_push,
  input  logic [DATA_W-1:0]     exp_data,
  output logic                  exp_full,
  output logic                  exp_empty,
  output logic [DEPTH_LOG2:0]   exp_level,
  output logic [31:0]           xfer_count,
  output logic [15:0]           err_count,
  output logic                  err,
  output logic                  proto_err,
  output logic                  ovf_err,
  output logic [DATA_W-1:0]     first_err_got,
  output logic [DATA_W-1:0]     first_err_exp
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0) ? 16'hACE1 : SEED;

  logic [15:0]           lfsr;
  logic                  fb;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DATA_W-1:0]     head;
  logic                  xfer;
  logic                  pop;
  logic                  push_ok;
  logic                  ovf;
  logic                  underflow;
  logic                  mismatch;
  logic                  derr;
  logic                  pend;
  logic [DATA_W-1:0]     held;
  logic                  proto_bad;

  assign fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign exp_full  = (exp_level == FULL_LVL);
  assign exp_empty = (exp_level == '0);
  assign head      = mem[rd_ptr];
  assign xfer      = snk.in_rdy & snk.in_ack;
  assign pop       = xfer & ~exp_empty;
  assign underflow = xfer & exp_empty;
  assign mismatch  = pop & (head != snk.in_data);
  assign derr      = mismatch | underflow;
  // a full FIFO still takes a push when the same edge pops
  assign push_ok   = exp_push & (~exp_full | pop);
  assign ovf       = exp_push & exp_full & ~pop;
  // a word offered and not taken must be re-offered unchanged
  assign proto_bad = pend &
    (~snk.in_rdy | (snk.in_data != held));

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= exp_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr          <= SEED_EFF;
      snk.in_ack    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      exp_level     <= '0;
      xfer_count    <= '0;
      err_count     <= '0;
      err           <= 1'b0;
      proto_err     <= 1'b0;
      ovf_err       <= 1'b0;
      first_err_got <= '0;
      first_err_exp <= '0;
      pend          <= 1'b0;
      held          <= '0;
    end else begin
      lfsr       <= {lfsr[14:0], fb};
      snk.in_ack <= (lfsr[3:0] >= stall_level);
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        exp_level <= exp_level + 1'b1;
      else if (pop && !push_ok)
        exp_level <= exp_level - 1'b1;
      if (ovf)  ovf_err <= 1'b1;
      if (xfer) xfer_count <= xfer_count + 32'd1;
      if (derr) begin
        if (err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
        err <= 1'b1;
        if (!err) begin
          first_err_got <= snk.in_data;
          first_err_exp <= underflow ? '0 : head;
        end
      end
      pend <= snk.in_rdy & ~snk.in_ack;
      if (snk.in_rdy && !snk.in_ack)
        held <= snk.in_data;
      if (proto_bad) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rdy_ack_sink_checker.sv
// Self-checking bench for rdy_ack_sink_checker.
// Directed scenarios plus a random phase against a queue-based model.
module tb_rdy_ack_sink_checker;
  logic        clk;
  logic        rstn;
  logic [3:0]  stall;
  logic        push;
  logic [31:0] pdata;
  logic        exp_full, exp_empty;
  logic [3:0]  exp_level;
  logic [31:0] xfer_count;
  logic [15:0] err_count;
  logic        err, proto_err, ovf_err;
  logic [31:0] fgot, fexp;

  rdy_ack_sink_checker_if #(.DATA_W(32)) bus ();

  rdy_ack_sink_checker #(
    .DATA_W(32), .DEPTH_LOG2(3), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rstn(rstn), .snk(bus),
    .stall_level(stall),
    .exp_push(push), .exp_data(pdata),
    .exp_full(exp_full), .exp_empty(exp_empty),
    .exp_level(exp_level),
    .xfer_count(xfer_count), .err_count(err_count),
    .err(err), .proto_err(proto_err), .ovf_err(ovf_err),
    .first_err_got(fgot), .first_err_exp(fexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  bit [15:0] m_lfsr;
  bit        m_ack;
  bit [31:0] m_xfer;
  int        m_errc;
  bit        m_err, m_perr, m_ovf;
  bit [31:0] m_fg, m_fe;
  bit [31:0] q[$];
  bit        m_pend;
  bit [31:0] m_held;
  bit        last_xfer;
  bit        rec1 [40];

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    vecs++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_ack = 0; m_xfer = 0; m_errc = 0;
    m_err = 0; m_perr = 0; m_ovf = 0; m_fg = 0; m_fe = 0;
    q.delete(); m_pend = 0; m_held = 0; last_xfer = 0;
  endtask

  task automatic model_edge(bit r, bit [31:0] d, bit p,
                            bit [31:0] pd);
    bit x, popped, full_b, de;
    bit [31:0] e;
    x = r & m_ack; popped = 0; de = 0; e = 0;
    full_b = (q.size() == 8);
    if (x) begin
      m_xfer++;
      if (q.size() > 0) begin
        e = q.pop_front(); popped = 1; de = (e != d);
      end else begin
        de = 1; e = 0;
      end
    end
    if (de) begin
      if (m_errc < 65535) m_errc++;
      if (!m_err) begin m_fg = d; m_fe = e; end
      m_err = 1;
    end
    if (p) begin
      if (!full_b || popped) q.push_back(pd);
      else m_ovf = 1;
    end
    if (m_pend && (!r || d != m_held)) m_perr = 1;
    m_pend = r & !m_ack;
    if (m_pend) m_held = d;
    last_xfer = x;
    m_ack = (m_lfsr[3:0] >= stall);
    m_lfsr = {m_lfsr[14:0],
      m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic check_all();
    chk("ack", bus.in_ack, m_ack);
    chk("level", exp_level, q.size());
    chk("empty", exp_empty, q.size() == 0);
    chk("full", exp_full, q.size() == 8);
    chk("xfer_count", xfer_count, m_xfer);
    chk("err_count", err_count, m_errc);
    chk("err", err, m_err);
    chk("proto_err", proto_err, m_perr);
    chk("ovf_err", ovf_err, m_ovf);
    chk("first_got", fgot, m_fg);
    chk("first_exp", fexp, m_fe);
  endtask

  task automatic step(bit r, bit [31:0] d, bit p, bit [31:0] pd);
    bus.in_rdy = r; bus.in_data = d; push = p; pdata = pd;
    @(posedge clk);
    model_edge(r, d, p, pd);
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic send(bit [31:0] w, bit p, bit [31:0] pd);
    for (int i = 0; i < 200; i++) begin
      step(1, w, p, pd);
      if (last_xfer) break;
    end
    bus.in_rdy = 0;
    if (!last_xfer) begin
      vecs++; miss++;
      $error("FAIL send_timeout got=no_ack exp=ack");
    end
  endtask

  task automatic do_reset();
    rstn = 0;
    #1;
    chk("rst_ack", bus.in_ack, 0);
    chk("rst_level", exp_level, 0);
    chk("rst_empty", exp_empty, 1);
    chk("rst_full", exp_full, 0);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_errc", err_count, 0);
    chk("rst_err", err, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_fgot", fgot, 0);
    chk("rst_fexp", fexp, 0);
    model_reset();
    bus.in_rdy = 0; bus.in_data = 0; push = 0; pdata = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    bit hold;
    bit [31:0] ns, np, d;
    rstn = 1; stall = 0; push = 0; pdata = 0;
    bus.in_rdy = 0; bus.in_data = 0;
    @(negedge clk);
    do_reset();

    // back-to-back with no backpressure
    step(0, 0, 1, 1); step(0, 0, 1, 2); step(0, 0, 1, 3);
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0);
    chk("t1_xfer", xfer_count, 3);
    chk("t1_err", err, 0);
    chk("t1_empty", exp_empty, 1);

    // repeatable ack pattern and held sender
    stall = 8;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0); rec1[i] = bus.in_ack;
    end
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      chk("ack_repeat", bus.in_ack, rec1[i]);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h10 + i);
    send(32'h10, 0, 0); send(32'h11, 0, 0);
    step(0, 0, 1, 32'h18); step(0, 0, 1, 32'h19);
    for (int i = 2; i < 10; i++) send(32'h10 + i, 0, 0);
    chk("t2_xfer", xfer_count, 10);
    chk("t2_errc", err_count, 0);

    // mismatch and first-error latch
    stall = 0;
    do_reset();
    step(0, 0, 1, 5); step(0, 0, 1, 6);
    send(5, 0, 0); send(7, 0, 0);
    chk("t3_errc", err_count, 1);
    chk("t3_fgot", fgot, 7);
    chk("t3_fexp", fexp, 6);
    step(0, 0, 1, 8); send(9, 0, 0);
    chk("t3_errc2", err_count, 2);
    chk("t3_fgot2", fgot, 7);

    // underflow with same-cycle push
    do_reset();
    idle(1);
    step(1, 32'hDEAD, 1, 32'hDEAD);
    chk("t4_errc", err_count, 1);
    chk("t4_fexp", fexp, 0);
    chk("t4_fgot", fgot, 32'hDEAD);
    chk("t4_level", exp_level, 1);

    // overflow, then push during pop at full
    do_reset();
    for (int i = 0; i < 9; i++) step(0, 0, 1, 100 + i);
    chk("t5_full", exp_full, 1);
    chk("t5_ovf", ovf_err, 1);
    send(100, 1, 200);
    chk("t5_level", exp_level, 8);
    chk("t5_ovf2", ovf_err, 1);

    // randomized traffic
    for (int r = 0; r < 3; r++) begin
      stall = 4'($urandom_range(0, 9));
      do_reset();
      hold = 0; ns = 0; np = 0; d = 0;
      for (int c = 0; c < 300; c++) begin
        bit rr, pp;
        pp = ($urandom_range(0, 2) == 0);
        if (hold) begin
          rr = 1;
          if ($urandom_range(0, 60) == 0) d = d ^ 32'h4;
        end else begin
          rr = $urandom_range(0, 1) == 1;
          d = ns;
          if ($urandom_range(0, 15) == 0) d = d ^ 32'h1;
        end
        step(rr, d, pp, np);
        if (pp) np++;
        if (last_xfer) ns++;
        hold = rr && !last_xfer;
      end
      bus.in_rdy = 0;
    end

    // protocol violation, then reset mid-burst
    stall = 15;
    do_reset();
    for (int i = 0; i < 100 && m_ack; i++) idle(1);
    step(1, 32'hA5, 0, 0);
    step(1, 32'h5A, 0, 0);
    chk("t6_proto", proto_err, 1);
    stall = 0;
    idle(1);
    for (int i = 0; i < 6; i++)
      step($urandom_range(0, 1) == 1, $urandom, 1, $urandom);
    @(posedge clk);
    #2;
    do_reset();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end
endmodule

// File: doc/rdy_ack_sink_checker.md
Name: rdy_ack_sink_checker

Overview:
- Receiving end of the rdy/ack pipeline handshake. A transfer occurs on a posedge clk where rdy=1 and ack=1.
- Terminates a pipeline output such as mem_wb. It drives ack with a seeded LFSR backpressure pattern that is repeatable from run to run.
- Checks each accepted word, in order, against an expected-value FIFO that the bench or a source-side monitor fills.
- Also flags handshake-rule violations by the sender. Synthesizable, so it can sit in an FPGA bring-up harness as well as in simulation.

Parameters:
- DATA_W, 32, data width.
- DEPTH_LOG2, 3, log2 of expected-FIFO depth (8 entries).
- SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_rdy  in  1  sender has valid data
- in_ack  out  1  sink accepts data (registered)
- in_data  in  DATA_W  sender data
- stall_level  in  4  backpressure strength; 0 means ack is always 1
- exp_push  in  1  push exp_data into the expected FIFO
- exp_data  in  DATA_W  expected value
- exp_full  out  1  FIFO full
- exp_empty  out  1  FIFO empty
- exp_level  out  DEPTH_LOG2+1  FIFO occupancy
- xfer_count  out  32  accepted transfers
- err_count  out  16  mismatches plus underflows
- err  out  1  sticky: any data error
- proto_err  out  1  sticky: handshake violation
- ovf_err  out  1  sticky: push while full with no pop
- first_err_got  out  DATA_W  in_data at the first data error
- first_err_exp  out  DATA_W  expected value at the first data error (0 for an underflow)

Behaviour:
- Reset (async, rstn=0):
  - in_ack=0, so the sink starts stalled.
  - LFSR=SEED; FIFO empty (exp_empty=1, exp_full=0, exp_level=0).
  - All counters, sticky flags and first_err_* are 0.
  - Reset mid-operation discards FIFO contents and any in-flight transfer.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every cycle after reset.
  - Registered next ack = (lfsr[3:0] >= stall_level). stall_level=0 gives ack=1 on every cycle after the first post-reset edge.
  - ack does not depend on in_rdy or FIFO state. Identical SEED and stall_level give an identical ack sequence.
- Transfer (xfer = in_rdy & in_ack at the edge):
  - xfer_count increments and wraps at 2^32.
  - FIFO not empty: pop the head and compare it to in_data.
  - FIFO empty: underflow; counts as a data error and there is no pop.
  - A same-cycle exp_push never satisfies the current transfer; the compare always uses the pre-push head.
- Data error (mismatch or underflow):
  - err_count increments, saturating at 16'hFFFF.
  - err is set.
  - If err was previously 0, latch first_err_got and first_err_exp.
- FIFO:
  - Circular, with DEPTH_LOG2-bit pointers that wrap, plus an occupancy counter.
  - Push when full without a same-cycle pop: data dropped, ovf_err set.
  - Push when full with a same-cycle pop: accepted, and the level stays at full.
  - Push and pop together at any level: level unchanged.
  - Status outputs are registered and reflect the state after the edge.
- Protocol checker (a held-word register captures in_data whenever in_rdy=1 and in_ack=0):
  - If that cycle was not a transfer, then on the next edge in_rdy must be 1 and in_data must equal the held word.
  - Otherwise proto_err is set.
  - in_rdy may drop only after a transfer.
  - proto_err does not affect compare or counting.
- Latency:
  - ack: one cycle from the LFSR state.
  - Status and error outputs: valid the cycle after the causing edge.

Test Plan:
- stall_level=0; push 1,2,3; sender offers 1,2,3 back-to-back -> ack=1 from the 2nd edge after reset; xfer_count=3, err=0, exp_empty=1.
- stall_level=8, SEED=16'hACE1; push 10 words; sender holds each word until ack -> all 10 accepted in order; err_count=0; ack pattern matches the golden LFSR model bit-for-bit across two runs.
- Push 5,6; sender sends 5,7 -> err=1, err_count=1, first_err_got=7, first_err_exp=6; a later mismatch leaves first_err_* unchanged.
- FIFO empty; sender transfers 0xDEAD with exp_push=1 (exp_data=0xDEAD) in the same cycle -> underflow: err_count=1, first_err_exp=0; exp_level=1 afterwards.
- Push 9 words with no transfers -> exp_full=1 after 8, ovf_err=1. Then push while a transfer pops -> exp_level stays 8 and ovf_err stays sticky.
- Sender raises rdy with 0xA5 while ack=0, then changes data to 0x5A before the transfer -> proto_err=1. Assert rstn=0 mid-burst -> all outputs return to their reset values asynchronously.
